// File: rtl/reg_file_2r1w_if.sv
`default_nettype none
// ============================================================================
//  Module      : reg_file_2r1w_if
//  Description : Bus bundle for the 2-read / 1-write register file. Carries
//                the clear, write and read signals. Clock and reset stay
//                plain ports on the register file itself.
//  Revision    : 1.0 - initial release
// ============================================================================
interface reg_file_2r1w_if #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 3
);
  localparam int DEPTH = 2 ** ADDR_W;

  logic              clr;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [WIDTH-1:0]  wdata;
  logic [ADDR_W-1:0] ra_addr;
  logic [ADDR_W-1:0] rb_addr;
  logic [WIDTH-1:0]  ra_data;
  logic [WIDTH-1:0]  rb_data;
  logic [DEPTH-1:0]  valid;

  // Requester side: the control FSM / datapath that issues writes and reads
  modport master (
    output clr, we, waddr, wdata, ra_addr, rb_addr,
    input  ra_data, rb_data, valid
  );

  // Register-file side
  modport slave (
    input  clr, we, waddr, wdata, ra_addr, rb_addr,
    output ra_data, rb_data, valid
  );
endinterface
`default_nettype wire

// File: rtl/reg_file_2r1w.sv
`default_nettype none
// ============================================================================
//  Module      : reg_file_2r1w
//  Description : DEPTH x WIDTH register file with one synchronous write port,
//                two combinational read ports, synchronous clear-all,
//                optional hardwired-zero register 0, optional write-through
//                bypass and per-register valid flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module reg_file_2r1w #(
  parameter int WIDTH    = 8,
  parameter int ADDR_W   = 3,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  wire logic          clk,
  input  wire logic          res,
  reg_file_2r1w_if.slave     bus
);
  localparam int DEPTH = 2 ** ADDR_W;

  // Storage and valid flags
  logic [WIDTH-1:0] regs_q [DEPTH];
  logic [WIDTH-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] valid_d;

  // Qualified write: reset released, no clear, and not aimed at a hardwired zero
  logic w_wr_zero;
  logic w_wr_en;
  logic w_byp_a;
  logic w_byp_b;
  logic [WIDTH-1:0] w_ra_data;
  logic [WIDTH-1:0] w_rb_data;

  assign w_wr_zero = (ZERO_REG != 0) && (bus.waddr == '0);
  assign w_wr_en   = res && bus.we && !bus.clr && !w_wr_zero;

  // Forwarding only happens for a write that will actually land, so clear,
  // reset and the zero register all suppress it automatically.
  assign w_byp_a = (BYPASS != 0) && w_wr_en && (bus.waddr == bus.ra_addr);
  assign w_byp_b = (BYPASS != 0) && w_wr_en && (bus.waddr == bus.rb_addr);

  // Next-state: clear beats write, otherwise update only the addressed entry
  always_comb begin
    regs_d  = regs_q;
    valid_d = valid_q;
    if (bus.clr) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_d[i] = '0;
      end
      valid_d = '0;
    end else if (w_wr_en) begin
      regs_d[bus.waddr]  = bus.wdata;
      valid_d[bus.waddr] = 1'b1;
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
      valid_q <= '0;
    end else begin
      regs_q  <= regs_d;
      valid_q <= valid_d;
    end
  end

  // Read port A: zero register first, then bypass, then storage; forced 0 in reset
  always_comb begin
    w_ra_data = '0;
    if (res) begin
      if ((ZERO_REG != 0) && (bus.ra_addr == '0)) begin
        w_ra_data = '0;
      end else if (w_byp_a) begin
        w_ra_data = bus.wdata;
      end else begin
        w_ra_data = regs_q[bus.ra_addr];
      end
    end
  end

  // Read port B: same selection as port A, independent address
  always_comb begin
    w_rb_data = '0;
    if (res) begin
      if ((ZERO_REG != 0) && (bus.rb_addr == '0)) begin
        w_rb_data = '0;
      end else if (w_byp_b) begin
        w_rb_data = bus.wdata;
      end else begin
        w_rb_data = regs_q[bus.rb_addr];
      end
    end
  end

  assign bus.ra_data = w_ra_data;
  assign bus.rb_data = w_rb_data;
  assign bus.valid   = valid_q;

endmodule
`default_nettype wire

// File: tb/tb_reg_file_2r1w.sv
`default_nettype none
// ============================================================================
//  Module      : tb_reg_file_2r1w
//  Description : Directed self-checking bench. Two instances share stimulus:
//                dut_a uses defaults (ZERO_REG=1, BYPASS=1), dut_b is the
//                plain-storage build (ZERO_REG=0, BYPASS=0).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_file_2r1w;
  logic       clk = 1'b0;
  logic       res = 1'b0;
  logic       clr = 1'b0;
  logic       we = 1'b0;
  logic [2:0] waddr = 3'd0;
  logic [7:0] wdata = 8'h00;
  logic [2:0] ra_addr = 3'd0;
  logic [2:0] rb_addr = 3'd0;

  int checks = 0;
  int failures = 0;

  reg_file_2r1w_if #(.WIDTH(8), .ADDR_W(3)) bus_a ();
  reg_file_2r1w_if #(.WIDTH(8), .ADDR_W(3)) bus_b ();

  assign bus_a.clr = clr;     assign bus_b.clr = clr;
  assign bus_a.we = we;       assign bus_b.we = we;
  assign bus_a.waddr = waddr; assign bus_b.waddr = waddr;
  assign bus_a.wdata = wdata; assign bus_b.wdata = wdata;
  assign bus_a.ra_addr = ra_addr; assign bus_b.ra_addr = ra_addr;
  assign bus_a.rb_addr = rb_addr; assign bus_b.rb_addr = rb_addr;

  reg_file_2r1w #(.WIDTH(8), .ADDR_W(3), .ZERO_REG(1), .BYPASS(1)) dut_a (
    .clk(clk), .res(res), .bus(bus_a)
  );
  reg_file_2r1w #(.WIDTH(8), .ADDR_W(3), .ZERO_REG(0), .BYPASS(0)) dut_b (
    .clk(clk), .res(res), .bus(bus_b)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    res = 1'b0;
    repeat (2) @(negedge clk);
    res = 1'b1;
    for (int i = 0; i < 8; i++) begin
      ra_addr = 3'(i);
      rb_addr = 3'(7 - i);
      #1;
      checks++;
      if (bus_a.ra_data !== 8'h00 || bus_a.rb_data !== 8'h00) begin
        failures++;
        $display("FAIL reset_read_a addr=%0d got ra=%h rb=%h exp 00", i, bus_a.ra_data, bus_a.rb_data);
      end
      checks++;
      if (bus_b.ra_data !== 8'h00 || bus_b.rb_data !== 8'h00) begin
        failures++;
        $display("FAIL reset_read_b addr=%0d got ra=%h rb=%h exp 00", i, bus_b.ra_data, bus_b.rb_data);
      end
    end
    checks++;
    if (bus_a.valid !== 8'h00 || bus_b.valid !== 8'h00) begin
      failures++;
      $display("FAIL reset_valid got a=%h b=%h exp 00", bus_a.valid, bus_b.valid);
    end
  endtask

  task automatic test_write();
    @(negedge clk); we = 1'b1; waddr = 3'd3; wdata = 8'hA5;
    @(negedge clk); waddr = 3'd5; wdata = 8'h3C;
    @(negedge clk); we = 1'b0; ra_addr = 3'd3; rb_addr = 3'd5;
    #1;
    checks++;
    if (bus_a.ra_data !== 8'hA5 || bus_a.rb_data !== 8'h3C) begin
      failures++;
      $display("FAIL write_data_a got ra=%h rb=%h exp A5 3C", bus_a.ra_data, bus_a.rb_data);
    end
    checks++;
    if (bus_b.ra_data !== 8'hA5 || bus_b.rb_data !== 8'h3C) begin
      failures++;
      $display("FAIL write_data_b got ra=%h rb=%h exp A5 3C", bus_b.ra_data, bus_b.rb_data);
    end
    checks++;
    if (bus_a.valid !== 8'h28 || bus_b.valid !== 8'h28) begin
      failures++;
      $display("FAIL write_valid got a=%h b=%h exp 28", bus_a.valid, bus_b.valid);
    end
  endtask

  task automatic test_zero_reg();
    @(negedge clk); we = 1'b1; waddr = 3'd0; wdata = 8'hFF; ra_addr = 3'd0; rb_addr = 3'd3;
    #1;
    checks++;
    if (bus_a.ra_data !== 8'h00) begin
      failures++;
      $display("FAIL zero_bypass_a got=%h exp 00", bus_a.ra_data);
    end
    @(negedge clk); we = 1'b0;
    #1;
    checks++;
    if (bus_a.ra_data !== 8'h00 || bus_a.valid !== 8'h28) begin
      failures++;
      $display("FAIL zero_reg_a got data=%h valid=%h exp 00 28", bus_a.ra_data, bus_a.valid);
    end
    checks++;
    if (bus_b.ra_data !== 8'hFF || bus_b.valid !== 8'h29) begin
      failures++;
      $display("FAIL zero_reg_b got data=%h valid=%h exp FF 29", bus_b.ra_data, bus_b.valid);
    end
  endtask

  task automatic test_bypass();
    @(negedge clk); we = 1'b1; waddr = 3'd2; wdata = 8'h11;
    @(negedge clk); wdata = 8'h77; ra_addr = 3'd2; rb_addr = 3'd2;
    #1;
    checks++;
    if (bus_a.ra_data !== 8'h77 || bus_a.rb_data !== 8'h77) begin
      failures++;
      $display("FAIL bypass_pre_a got ra=%h rb=%h exp 77 77", bus_a.ra_data, bus_a.rb_data);
    end
    checks++;
    if (bus_b.ra_data !== 8'h11 || bus_b.rb_data !== 8'h11) begin
      failures++;
      $display("FAIL bypass_pre_b got ra=%h rb=%h exp 11 11", bus_b.ra_data, bus_b.rb_data);
    end
    @(negedge clk); we = 1'b0;
    #1;
    checks++;
    if (bus_a.ra_data !== 8'h77 || bus_a.rb_data !== 8'h77 || bus_a.valid !== 8'h2C) begin
      failures++;
      $display("FAIL bypass_post_a got ra=%h rb=%h valid=%h exp 77 77 2C", bus_a.ra_data, bus_a.rb_data, bus_a.valid);
    end
    checks++;
    if (bus_b.ra_data !== 8'h77 || bus_b.rb_data !== 8'h77 || bus_b.valid !== 8'h2D) begin
      failures++;
      $display("FAIL bypass_post_b got ra=%h rb=%h valid=%h exp 77 77 2D", bus_b.ra_data, bus_b.rb_data, bus_b.valid);
    end
  endtask

  task automatic test_clear();
    for (int i = 1; i < 8; i++) begin
      @(negedge clk); we = 1'b1; waddr = 3'(i); wdata = 8'h10 + 8'(i);
    end
    @(negedge clk); clr = 1'b1; we = 1'b1; waddr = 3'd4; wdata = 8'h99;
    ra_addr = 3'd4; rb_addr = 3'd4;
    #1;
    checks++;
    if (bus_a.ra_data !== 8'h14 || bus_a.rb_data !== 8'h14) begin
      failures++;
      $display("FAIL clear_no_bypass_a got ra=%h rb=%h exp 14 14", bus_a.ra_data, bus_a.rb_data);
    end
    @(negedge clk); clr = 1'b0; we = 1'b0;
    for (int i = 0; i < 8; i++) begin
      ra_addr = 3'(i);
      rb_addr = 3'(i);
      #1;
      checks++;
      if (bus_a.ra_data !== 8'h00 || bus_b.rb_data !== 8'h00) begin
        failures++;
        $display("FAIL clear_read addr=%0d got a=%h b=%h exp 00", i, bus_a.ra_data, bus_b.rb_data);
      end
    end
    checks++;
    if (bus_a.valid !== 8'h00 || bus_b.valid !== 8'h00) begin
      failures++;
      $display("FAIL clear_valid got a=%h b=%h exp 00", bus_a.valid, bus_b.valid);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk); we = 1'b1; waddr = 3'd1; wdata = 8'h21;
    @(negedge clk); waddr = 3'd6; wdata = 8'h5A; ra_addr = 3'd6; rb_addr = 3'd1;
    #1;
    checks++;
    if (bus_a.ra_data !== 8'h5A || bus_a.rb_data !== 8'h21 || bus_b.ra_data !== 8'h00) begin
      failures++;
      $display("FAIL midrst_pre got a.ra=%h a.rb=%h b.ra=%h exp 5A 21 00", bus_a.ra_data, bus_a.rb_data, bus_b.ra_data);
    end
    #2; res = 1'b0;
    #1;
    checks++;
    if (bus_a.ra_data !== 8'h00 || bus_a.rb_data !== 8'h00 || bus_a.valid !== 8'h00) begin
      failures++;
      $display("FAIL midrst_async_a got ra=%h rb=%h valid=%h exp 00 00 00", bus_a.ra_data, bus_a.rb_data, bus_a.valid);
    end
    checks++;
    if (bus_b.ra_data !== 8'h00 || bus_b.rb_data !== 8'h00 || bus_b.valid !== 8'h00) begin
      failures++;
      $display("FAIL midrst_async_b got ra=%h rb=%h valid=%h exp 00 00 00", bus_b.ra_data, bus_b.rb_data, bus_b.valid);
    end
    @(negedge clk); we = 1'b0; res = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (bus_a.ra_data !== 8'h00 || bus_a.rb_data !== 8'h00 || bus_b.ra_data !== 8'h00 || bus_b.valid !== 8'h00) begin
      failures++;
      $display("FAIL midrst_after got a.ra=%h a.rb=%h b.ra=%h b.valid=%h exp 00", bus_a.ra_data, bus_a.rb_data, bus_b.ra_data, bus_b.valid);
    end
  endtask

  // Scenario sequence
  initial begin
    test_reset();
    test_write();
    test_zero_reg();
    test_bypass();
    test_clear();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
